// File: rtl/ch_list_pkg.sv
// Shared types and constants for the chID list merge block.
// State encoding, RAM map bases and the default sizing of the slot tables.
// The optional hops/qValue update path is enabled by defining CHLIST_HOPS_QV_EN.
package ch_list_pkg;

    // Default sizing
    localparam int WORD_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 11;
    localparam int MAX_NBR_DEF  = 8;
    localparam int MAX_CHID_DEF = 8;

    // Byte addresses of the shared RAM tables (words at 2-byte stride)
    localparam int NBR_CNT_ADDR = 'h2B4;
    localparam int KCH_CNT_ADDR = 'h2B2;
    localparam int KCH_BASE     = 'h012;
    localparam int HOPS_BASE    = 'h032;
    localparam int QV_BASE      = 'h052;
    localparam int CID_CNT_BASE = 'h2B8;
    localparam int CID_BASE     = 'h1B2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_NBR  = 4'd1,
        ST_RD_KCNT = 4'd2,
        ST_RD_KCH  = 4'd3,
        ST_RD_CCNT = 4'd4,
        ST_SCAN    = 4'd5,
        ST_APPEND  = 4'd6,
        ST_WR_CNT  = 4'd7,
        ST_RD_HOPS = 4'd8,
        ST_WR_QV   = 4'd9,
        ST_NEXT    = 4'd10,
        ST_DONE    = 4'd11
    } state_t;

    // Byte address of slot k in row i of a per-neighbour table (default row width)
    function automatic int unsigned slot_addr(input int unsigned base,
                                              input int unsigned i,
                                              input int unsigned k);
        return base + 2 * (i * MAX_CHID_DEF + k);
    endfunction

endpackage

// File: rtl/chlist_addr_gen.sv
// Combinational RAM address selection for the chID list merge FSM.
// Each state owns exactly one table; idle/bookkeeping states drive address 0.
module chlist_addr_gen
    import ch_list_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_CHID = MAX_CHID_DEF
) (
    input  state_t            state,
    input  logic [WORD_W-1:0] i_idx,
    input  logic [WORD_W-1:0] j_idx,
    input  logic [WORD_W-1:0] k_idx,
    output logic [ADDR_W-1:0] mem_addr
);

    logic [31:0] slot_off;
    logic [31:0] full_addr;

    // Byte offset of slot (i,k) inside a row-major per-neighbour table
    assign slot_off = ((32'(i_idx) * 32'(MAX_CHID)) + 32'(k_idx)) << 1;

    // Pick the table address belonging to the current state
    always_comb begin
        full_addr = 32'd0;
        case (state)
            ST_RD_NBR:            full_addr = 32'(NBR_CNT_ADDR);
            ST_RD_KCNT:           full_addr = 32'(KCH_CNT_ADDR);
            ST_RD_KCH:            full_addr = 32'(KCH_BASE) + (32'(j_idx) << 1);
            ST_RD_HOPS:           full_addr = 32'(HOPS_BASE) + (32'(j_idx) << 1);
            ST_RD_CCNT, ST_WR_CNT: full_addr = 32'(CID_CNT_BASE) + (32'(i_idx) << 1);
            ST_SCAN, ST_APPEND:   full_addr = 32'(CID_BASE) + slot_off;
            ST_WR_QV:             full_addr = 32'(QV_BASE) + slot_off;
            default:              full_addr = 32'd0;
        endcase
    end

    assign mem_addr = ADDR_W'(full_addr);

endmodule

// File: rtl/ch_list_merge.sv
// Known-CH / chID list merge engine.
// For every known CH j and neighbour i, scans chID[i][*] and appends CH j when
// absent (bounded by MAX_CHID, sticky overflow otherwise), then bumps chIDcount[i].
// Every read spends two cycles: phase 0 presents the address, phase 1 captures
// the data returned by the single-cycle-latency RAM.
// Optional: define CHLIST_HOPS_QV_EN to also write qValue[i][cnt] = hops[j]+1
// after each append.
module ch_list_merge
    import ch_list_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_NBR  = MAX_NBR_DEF,
    parameter int MAX_CHID = MAX_CHID_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_t            state_reg, state_next;
    logic              phase_reg, phase_next;
    logic [WORD_W-1:0] i_reg, i_next;
    logic [WORD_W-1:0] j_reg, j_next;
    logic [WORD_W-1:0] k_reg, k_next;
    logic [WORD_W-1:0] nbr_reg, nbr_next;
    logic [WORD_W-1:0] kcnt_reg, kcnt_next;
    logic [WORD_W-1:0] cnt_reg, cnt_next;
    logic [WORD_W-1:0] kch_reg, kch_next;
    logic [WORD_W-1:0] hops_reg, hops_next;
    logic              ovf_reg, ovf_next;

    logic [ADDR_W-1:0] addr_w;
    logic [WORD_W-1:0] nbr_clamped;
    logic [WORD_W-1:0] cnt_clamped;
    logic [WORD_W:0]   i_inc;
    logic [WORD_W:0]   j_inc;

    chlist_addr_gen #(
        .WORD_W   (WORD_W),
        .ADDR_W   (ADDR_W),
        .MAX_CHID (MAX_CHID)
    ) u_addr_gen (
        .state    (state_reg),
        .i_idx    (i_reg),
        .j_idx    (j_reg),
        .k_idx    (k_reg),
        .mem_addr (addr_w)
    );

    // Clamp stored counts so a corrupt table can never index past a row
    assign nbr_clamped = (mem_rdata > WORD_W'(MAX_NBR))  ? WORD_W'(MAX_NBR)  : mem_rdata;
    assign cnt_clamped = (mem_rdata > WORD_W'(MAX_CHID)) ? WORD_W'(MAX_CHID) : mem_rdata;
    assign i_inc       = {1'b0, i_reg} + 1'b1;
    assign j_inc       = {1'b0, j_reg} + 1'b1;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
            phase_reg <= 1'b0;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            nbr_reg   <= '0;
            kcnt_reg  <= '0;
            cnt_reg   <= '0;
            kch_reg   <= '0;
            hops_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            nbr_reg   <= nbr_next;
            kcnt_reg  <= kcnt_next;
            cnt_reg   <= cnt_next;
            kch_reg   <= kch_next;
            hops_reg  <= hops_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        nbr_next   = nbr_reg;
        kcnt_next  = kcnt_reg;
        cnt_next   = cnt_reg;
        kch_next   = kch_reg;
        hops_next  = hops_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RD_NBR;
                    phase_next = 1'b0;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    nbr_next   = '0;
                    kcnt_next  = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_RD_NBR: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    nbr_next   = nbr_clamped;
                    state_next = ST_RD_KCNT;
                end
            end
            ST_RD_KCNT: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    kcnt_next = mem_rdata;
                    if (nbr_reg == '0 || mem_rdata == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RD_KCH;
                    end
                end
            end
            ST_RD_KCH: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    kch_next   = mem_rdata;
                    state_next = ST_RD_CCNT;
                end
            end
            ST_RD_CCNT: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    cnt_next   = cnt_clamped;
                    k_next     = '0;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (k_reg >= cnt_reg) begin
                    // Whole list scanned without a hit: append if there is room
                    phase_next = 1'b0;
                    if (cnt_reg < WORD_W'(MAX_CHID)) begin
                        state_next = ST_APPEND;
                    end else begin
                        ovf_next   = 1'b1;
                        state_next = ST_NEXT;
                    end
                end else begin
                    phase_next = ~phase_reg;
                    if (phase_reg) begin
                        if (mem_rdata == kch_reg) begin
                            state_next = ST_NEXT;
                        end else begin
                            k_next = k_reg + 1'b1;
                        end
                    end
                end
            end
            ST_APPEND: begin
                state_next = ST_WR_CNT;
            end
            ST_WR_CNT: begin
`ifdef CHLIST_HOPS_QV_EN
                state_next = ST_RD_HOPS;
                phase_next = 1'b0;
`else
                state_next = ST_NEXT;
`endif
            end
            ST_RD_HOPS: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    hops_next  = mem_rdata;
                    state_next = ST_WR_QV;
                end
            end
            ST_WR_QV: begin
                state_next = ST_NEXT;
            end
            ST_NEXT: begin
                phase_next = 1'b0;
                if (i_inc >= {1'b0, nbr_reg}) begin
                    i_next = '0;
                    if (j_inc >= {1'b0, kcnt_reg}) begin
                        state_next = ST_DONE;
                    end else begin
                        j_next     = j_inc[WORD_W-1:0];
                        state_next = ST_RD_KCH;
                    end
                end else begin
                    i_next     = i_inc[WORD_W-1:0];
                    state_next = ST_RD_KCH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = 1'b0;
            end
        endcase
    end

    // Outputs decoded from state; all forced low while reset is held
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        overflow  = 1'b0;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        if (nrst) begin
            overflow = ovf_reg;
            mem_addr = addr_w;
            case (state_reg)
                ST_IDLE: begin
                end
                ST_DONE: begin
                    done = 1'b1;
                end
                ST_APPEND: begin
                    busy      = 1'b1;
                    mem_wr_en = 1'b1;
                    mem_wdata = kch_reg;
                end
                ST_WR_CNT: begin
                    busy      = 1'b1;
                    mem_wr_en = 1'b1;
                    mem_wdata = cnt_reg + 1'b1;
                end
                ST_WR_QV: begin
                    busy      = 1'b1;
                    mem_wr_en = 1'b1;
                    mem_wdata = hops_reg + 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

endmodule
